verilog_wide_adder_seq: RTL
===========================

# verilog_wide_adder_seq

Byte-serial sequencer that performs multi-byte addition by time-multiplexing the team's 8-bit combinational adder (`verilog_adder`). It sits directly around that adder: it drives the adder's `x`/`y`/`carry_in` inputs one byte per cycle, LSB first, and consumes its `sum`/`carry_output_bit` results. It registers the inter-byte carry and assembles the wide result. Operands enter and results leave through valid/ready handshakes.

## Interface
- `NUM_BYTES`, default 4: operand width in bytes; legal range is ≥ 1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  8*NUM_BYTES  addend A.
- `in_b`  in  8*NUM_BYTES  addend B.
- `in_carry`  in  1  carry into byte 0.
- `adder_x`  out  8  to adder `x`.
- `adder_y`  out  8  to adder `y`.
- `adder_carry_in`  out  1  to adder `carry_in`.
- `adder_sum`  in  8  from adder `sum`.
- `adder_carry_out`  in  1  from adder `carry_output_bit`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  8*NUM_BYTES  A + B + carry, low 8*NUM_BYTES bits.
- `out_carry`  out  1  carry out of the top byte.
- `busy`  out  1  high in RUN or DONE.

## Operation
- **States:** IDLE, RUN, DONE. The byte index `idx` is `$clog2(NUM_BYTES)` bits wide, with a minimum width of 1.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_a`/`in_b` into the operand registers, set carry_reg=`in_carry`, set idx=0, go to RUN.
- **RUN**
  - Combinational drive: `adder_x`=A[8*idx +: 8], `adder_y`=B[8*idx +: 8], `adder_carry_in`=carry_reg.
  - Each edge: sum_reg[8*idx +: 8] ← `adder_sum`; carry_reg ← `adder_carry_out`; idx ← idx+1.
  - When idx==NUM_BYTES-1, that edge moves the state to DONE instead of incrementing idx further.
- **DONE**
  - `out_valid`=1.
  - `out_sum`=sum_reg and `out_carry`=carry_reg, both held stable.
  - On `out_ready`: go to IDLE.
- **Outside RUN:** `adder_x`, `adder_y` and `adder_carry_in` are driven to 0.
- **Output qualification:** `out_sum`/`out_carry` are meaningful only while `out_valid`=1. They hold their last values otherwise.
- **Ready gating:** `in_ready`=0 in RUN and DONE. There is no operand overlap; `in_valid` is ignored there.
- **Arithmetic:** the result is exactly (A + B + `in_carry`) mod 2^(8*NUM_BYTES); `out_carry` is bit 8*NUM_BYTES of the full sum. Carry ripples only through carry_reg, never combinationally across bytes.
- **Reset** (`rst_n`=0 at an edge), from any state including mid-RUN:
  - state=IDLE, idx=0, carry_reg=0, sum_reg=0.
  - The in-flight operation is discarded and no result is emitted.
- **Reset output values:** `in_ready`=1, `out_valid`=0, `busy`=0, `out_sum`=0, `out_carry`=0, adder drives=0.

## Timing
- Let the input handshake occur at edge E0.
- Byte k is presented to the adder during cycle (E0+k, E0+k+1) and captured at edge E0+k+1.
- State becomes DONE at edge E0+NUM_BYTES, so `out_valid` rises NUM_BYTES cycles after acceptance.
- With `out_ready` held high:
  - the output handshake occurs at edge E0+NUM_BYTES+1;
  - `in_ready` returns in the following cycle;
  - sustained throughput is one operation per NUM_BYTES+2 cycles.
- `out_valid` never drops without a handshake.
- `out_ready` asserted before `out_valid` has no effect.
- For NUM_BYTES=1: RUN lasts exactly one cycle; idx stays 0.
- The adder is purely combinational. The path `adder_*` out → `adder_sum`/`adder_carry_out` in must close in one cycle; no extra pipeline stage is allowed.

## Test plan
Every scenario uses a real `verilog_adder` instance on the adder ports.

- **Full carry ripple:** NUM_BYTES=4, A=0xFFFFFFFF, B=0x00000001, carry=0 → `out_sum`=0x00000000, `out_carry`=1, `out_valid` exactly 4 cycles after acceptance.
- **Carry-in only:** A=0x12345678, B=0x00000000, carry=1 → `out_sum`=0x12345679, `out_carry`=0.
- **Back-pressure:**
  - A=0x80000000, B=0x80000000; hold `out_ready`=0 for 5 cycles → `out_sum`=0, `out_carry`=1, all stable.
  - `in_ready`=0 throughout, and `in_valid` pulses are ignored.
  - Raising `out_ready` → IDLE the next cycle.
- **Reset mid-RUN:** assert `rst_n`=0 for one edge while idx=2 → all outputs at reset values next cycle, and no `out_valid`. A following op A=1, B=2 yields 3.
- **Back-to-back with constant `out_ready`=1:** 3 ops, each result correct; operand accepts spaced exactly 6 cycles apart.
- **NUM_BYTES=1:** A=0xFF, B=0xFF, carry=1 → `out_sum`=0xFF, `out_carry`=1, `out_valid` 1 cycle after acceptance.

Source files
------------

// File: rtl/verilog_wide_adder_seq.sv
// Byte-serial wide adder: walks operands LSB-first through one external 8-bit
// combinational adder, rippling the carry through a register between bytes.

module verilog_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_output_bit
);
    assign {carry_output_bit, sum} = {1'b0, x} + {1'b0, y} + {8'd0, carry_in};
endmodule

module verilog_wide_adder_seq #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_a,
    input  logic [8*NUM_BYTES-1:0] in_b,
    input  logic                   in_carry,
    output logic [7:0]             adder_x,
    output logic [7:0]             adder_y,
    output logic                   adder_carry_in,
    input  logic [7:0]             adder_sum,
    input  logic                   adder_carry_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_sum,
    output logic                   out_carry,
    output logic                   busy
);
    localparam int W     = 8 * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic [W-1:0]     r_out_sum;
    logic             r_out_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [7:0]       w_x;
    logic [7:0]       w_y;
    logic [W-1:0]     w_next_sum;
    logic             w_run;

    // Byte select for the adder, and the partial result with the current byte merged in
    always_comb begin
        w_x        = 8'd0;
        w_y        = 8'd0;
        w_next_sum = r_sum;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_x                  = r_a[8*k +: 8];
                w_y                  = r_b[8*k +: 8];
                w_next_sum[8*k +: 8] = adder_sum;
            end
        end
    end

    assign w_run          = (r_state == S_RUN);
    assign adder_x        = w_run ? w_x : 8'd0;
    assign adder_y        = w_run ? w_y : 8'd0;
    assign adder_carry_in = w_run & r_carry;

    // Result is copied into its own register on the last byte so it holds outside DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= in_carry;
                        r_idx      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_next_sum;
                    r_carry <= adder_carry_out;
                    if (r_idx == LAST_IDX) begin
                        r_state     <= S_DONE;
                        r_out_sum   <= w_next_sum;
                        r_out_carry <= adder_carry_out;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;
endmodule
